pma_prog: RTL and testbench

Run-time programmable Physical Memory Attribute checker. It replaces the fixed-map PMA in the ceres memory path with NUM_REGIONS software-configurable regions. Each region has a base, a mask, attribute bits and a lock bit. Requests from the fetch/LSU side go through a registered valid/ready lookup stage, and the first access fault is captured in sticky registers for the trap handler.

---
 rtl/pma_prog.sv | 203 ++++++++++++++++++++
 tb/tb_pma_prog.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_prog.sv
// Run-time programmable PMA checker: NUM_REGIONS base/mask regions, registered lookup stage,
// sticky first-fault capture. Optional fault counter enabled by PMA_FAULT_CNT_EN.
module pma_prog #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     NUM_REGIONS = 8,
   parameter logic [XLEN-1:0] RST_BASE0   = 32'h8000_0000,
   parameter logic [XLEN-1:0] RST_MASK0   = 32'h7FFF_FFFF,
   parameter int unsigned     CFG_AW      = $clog2(NUM_REGIONS*4)+1,
   localparam int unsigned    RW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [XLEN-1:0]   req_addr_i,
   input  logic [1:0]        req_type_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_uncached_o,
   output logic              rsp_memregion_o,
   output logic              rsp_allowed_o,
   output logic [RW-1:0]     rsp_region_o,
   input  logic              cfg_we_i,
   input  logic              cfg_re_i,
   input  logic [CFG_AW-1:0] cfg_addr_i,
   input  logic [XLEN-1:0]   cfg_wdata_i,
   output logic [XLEN-1:0]   cfg_rdata_o
);

   localparam int unsigned LW = CFG_AW - 1;

   logic [XLEN-1:0] base_q [NUM_REGIONS];
   logic [XLEN-1:0] mask_q [NUM_REGIONS];
   logic [7:0]      attr_q [NUM_REGIONS];

   logic            rsp_valid_q;
   logic            rsp_uncached_q;
   logic            rsp_memregion_q;
   logic            rsp_allowed_q;
   logic [RW-1:0]   rsp_region_q;
   logic [XLEN-1:0] cfg_rdata_q;

   logic            fault_valid_q;
   logic [XLEN-1:0] fault_addr_q;
   logic [1:0]      fault_type_q;
   logic [3:0]      fault_region_q;
   logic            fault_nomatch_q;

   logic            glob;
   logic [LW-1:0]   laddr;
   logic [31:0]     ridx;
   logic [31:0]     gword;
   logic [1:0]      word;
   logic            accept;
   logic            hit;
   logic [RW-1:0]   hit_idx;
   logic [7:0]      hit_attr;
   logic            perm;
   logic            allowed;
   logic            fault;
   logic            fault_clr;
   logic [XLEN-1:0] rd_val;

`ifdef PMA_FAULT_CNT_EN
   logic [15:0]     cnt_q;
   logic            cnt_clr;
`endif

   assign glob        = cfg_addr_i[CFG_AW-1];
   assign laddr       = cfg_addr_i[LW-1:0];
   assign ridx        = 32'(laddr >> 2);
   assign gword       = 32'(laddr);
   assign word        = cfg_addr_i[1:0];
   assign req_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept      = req_valid_i && req_ready_o;

   // Lowest-index enabled region whose unmasked bits equal the request address wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_attr = '0;
      for (int i = 0; i < int'(NUM_REGIONS); i++) begin
         if (!hit && attr_q[i][5] &&
             ((req_addr_i & ~mask_q[i]) == (base_q[i] & ~mask_q[i]))) begin
            hit      = 1'b1;
            hit_idx  = RW'(i);
            hit_attr = attr_q[i];
         end
      end
      case (req_type_i)
         2'd0:    perm = hit_attr[0];
         2'd1:    perm = hit_attr[1];
         2'd2:    perm = hit_attr[2];
         default: perm = 1'b0;
      endcase
      allowed = hit && hit_attr[3] && perm;
   end

   assign fault     = accept && !allowed;
   assign fault_clr = cfg_we_i && glob && (gword == 32'd1) && cfg_wdata_i[0];
`ifdef PMA_FAULT_CNT_EN
   assign cnt_clr   = cfg_we_i && glob && (gword == 32'd2);
`endif

   always_comb begin
      rd_val = '0;
      if (!glob) begin
         for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            if (ridx == 32'(i)) begin
               case (word)
                  2'd0:    rd_val = base_q[i];
                  2'd1:    rd_val = mask_q[i];
                  2'd2:    rd_val = XLEN'(attr_q[i]);
                  default: rd_val = '0;
               endcase
            end
         end
      end else if (gword == 32'd0) begin
         rd_val = fault_addr_q;
      end else if (gword == 32'd1) begin
         rd_val = XLEN'({fault_nomatch_q, 1'b0, fault_region_q, fault_type_q, fault_valid_q});
`ifdef PMA_FAULT_CNT_EN
      end else if (gword == 32'd2) begin
         rd_val = XLEN'(cnt_q);
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            base_q[i] <= (i == 0) ? RST_BASE0 : '0;
            mask_q[i] <= (i == 0) ? RST_MASK0 : '0;
            attr_q[i] <= (i == 0) ? 8'h2F : 8'h00;
         end
         rsp_valid_q     <= 1'b0;
         rsp_uncached_q  <= 1'b0;
         rsp_memregion_q <= 1'b0;
         rsp_allowed_q   <= 1'b0;
         rsp_region_q    <= '0;
         cfg_rdata_q     <= '0;
         fault_valid_q   <= 1'b0;
         fault_addr_q    <= '0;
         fault_type_q    <= '0;
         fault_region_q  <= '0;
         fault_nomatch_q <= 1'b0;
      end else begin
         // Locked regions ignore writes; attr bit 6 always reads 0.
         for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            if (cfg_we_i && !glob && (ridx == 32'(i)) && !attr_q[i][7]) begin
               case (word)
                  2'd0:    base_q[i] <= cfg_wdata_i;
                  2'd1:    mask_q[i] <= cfg_wdata_i;
                  2'd2:    attr_q[i] <= cfg_wdata_i[7:0] & 8'hBF;
                  default: ;
               endcase
            end
         end
         if (accept) begin
            rsp_valid_q     <= 1'b1;
            rsp_uncached_q  <= hit && hit_attr[4];
            rsp_memregion_q <= hit && hit_attr[3];
            rsp_allowed_q   <= allowed;
            rsp_region_q    <= hit_idx;
         end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
         if (cfg_re_i) begin
            cfg_rdata_q <= rd_val;
         end
         // A clear in the same cycle as a new fault still captures the new fault.
         if (fault && (!fault_valid_q || fault_clr)) begin
            fault_valid_q   <= 1'b1;
            fault_addr_q    <= req_addr_i;
            fault_type_q    <= req_type_i;
            fault_region_q  <= 4'(hit_idx);
            fault_nomatch_q <= !hit;
         end else if (fault_clr) begin
            fault_valid_q <= 1'b0;
         end
      end
   end

`ifdef PMA_FAULT_CNT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= fault ? 16'd1 : 16'd0;
      end else if (fault && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end
`endif

   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_uncached_o  = rsp_uncached_q;
   assign rsp_memregion_o = rsp_memregion_q;
   assign rsp_allowed_o   = rsp_allowed_q;
   assign rsp_region_o    = rsp_region_q;
   assign cfg_rdata_o     = cfg_rdata_q;

endmodule

// File: tb/tb_pma_prog.sv
// Self-checking bench for pma_prog: directed scenarios plus randomized traffic against an
// array-based reference model of the region map, fault registers and output handshake.
module tb_pma_prog;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_type;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_uncached;
   logic        rsp_memregion;
   logic        rsp_allowed;
   logic [2:0]  rsp_region;
   logic        cfg_we;
   logic        cfg_re;
   logic [5:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;

   pma_prog dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_addr_i      (req_addr),
      .req_type_i      (req_type),
      .rsp_valid_o     (rsp_valid),
      .rsp_ready_i     (rsp_ready),
      .rsp_uncached_o  (rsp_uncached),
      .rsp_memregion_o (rsp_memregion),
      .rsp_allowed_o   (rsp_allowed),
      .rsp_region_o    (rsp_region),
      .cfg_we_i        (cfg_we),
      .cfg_re_i        (cfg_re),
      .cfg_addr_i      (cfg_addr),
      .cfg_wdata_i     (cfg_wdata),
      .cfg_rdata_o     (cfg_rdata)
   );

   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference model state
   logic [31:0] m_base [8];
   logic [31:0] m_mask [8];
   logic [7:0]  m_attr [8];
   logic        m_fv;
   logic [31:0] m_faddr;
   logic [1:0]  m_ftype;
   logic [3:0]  m_freg;
   logic        m_fnm;
   logic [15:0] m_cnt;
   logic        e_valid, e_unc, e_mem, e_allowed;
   logic [2:0]  e_reg;
   logic [31:0] e_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_base[i] = 32'h0;
         m_mask[i] = 32'h0;
         m_attr[i] = 8'h0;
      end
      m_base[0] = 32'h8000_0000;
      m_mask[0] = 32'h7FFF_FFFF;
      m_attr[0] = 8'h2F;
      m_fv = 1'b0; m_faddr = '0; m_ftype = '0; m_freg = '0; m_fnm = 1'b0; m_cnt = '0;
      e_valid = 1'b0; e_unc = 1'b0; e_mem = 1'b0; e_allowed = 1'b0; e_reg = '0; e_rdata = '0;
   endtask

   task automatic mlook(input logic [31:0] a, input logic [1:0] t, output logic hit,
                        output logic [2:0] rg, output logic al, output logic un,
                        output logic me);
      hit = 1'b0; rg = '0; al = 1'b0; un = 1'b0; me = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!hit && m_attr[i][5] && (((a ^ m_base[i]) & ~m_mask[i]) == 32'h0)) begin
            hit = 1'b1;
            rg  = 3'(i);
         end
      end
      if (hit) begin
         me = m_attr[rg][3];
         un = m_attr[rg][4];
         al = me && (t != 2'd3) && m_attr[rg][t];
      end
   endtask

   function automatic logic [31:0] mread(input logic [5:0] a);
      if (!a[5]) begin
         case (a[1:0])
            2'd0:    return m_base[a[4:2]];
            2'd1:    return m_mask[a[4:2]];
            2'd2:    return {24'h0, m_attr[a[4:2]] & 8'hBF};
            default: return 32'h0;
         endcase
      end
      case (a[4:0])
         5'd0:    return m_faddr;
         5'd1:    return {23'h0, m_fnm, 1'b0, m_freg, m_ftype, m_fv};
`ifdef PMA_FAULT_CNT_EN
         5'd2:    return {16'h0, m_cnt};
`endif
         default: return 32'h0;
      endcase
   endfunction

   // One clock cycle, entered and left on a falling edge.
   task automatic step(input logic we, input logic re, input logic [5:0] a,
                       input logic [31:0] wd, input logic rv, input logic [31:0] ra,
                       input logic [1:0] rt, input logic rr);
      logic rdy, hit, al, un, me, clr, acc;
      logic [2:0] rg;
      cfg_we = we; cfg_re = re; cfg_addr = a; cfg_wdata = wd;
      req_valid = rv; req_addr = ra; req_type = rt; rsp_ready = rr;
      #1;
      rdy = !e_valid || rr;
      check("req_ready", 32'(req_ready), 32'(rdy));
      acc = rv && rdy;
      mlook(ra, rt, hit, rg, al, un, me);
      if (re) e_rdata = mread(a);
      clr = we && (a == 6'h21) && wd[0];
      if (acc) begin
         e_valid = 1'b1; e_unc = un; e_mem = me; e_allowed = al; e_reg = rg;
      end else if (rr) begin
         e_valid = 1'b0;
      end
      if (acc && !al && (!m_fv || clr)) begin
         m_fv = 1'b1; m_faddr = ra; m_ftype = rt; m_freg = {1'b0, rg}; m_fnm = !hit;
      end else if (clr) begin
         m_fv = 1'b0;
      end
      if (we && a == 6'h22) m_cnt = (acc && !al) ? 16'd1 : 16'd0;
      else if (acc && !al && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (we && !a[5] && !m_attr[a[4:2]][7]) begin
         case (a[1:0])
            2'd0:    m_base[a[4:2]] = wd;
            2'd1:    m_mask[a[4:2]] = wd;
            2'd2:    m_attr[a[4:2]] = wd[7:0];
            default: ;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      if (e_valid) begin
         check("rsp_allowed", 32'(rsp_allowed), 32'(e_allowed));
         check("rsp_memregion", 32'(rsp_memregion), 32'(e_mem));
         check("rsp_uncached", 32'(rsp_uncached), 32'(e_unc));
         check("rsp_region", 32'(rsp_region), 32'(e_reg));
      end
      if (re) check("cfg_rdata", cfg_rdata, e_rdata);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 6'h0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1);
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d);
      step(1'b1, 1'b0, a, d, 1'b0, 32'h0, 2'd0, 1'b1);
   endtask

   task automatic rd(input logic [5:0] a);
      step(1'b0, 1'b1, a, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1);
   endtask

   task automatic look(input logic [31:0] ra, input logic [1:0] rt);
      step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, ra, rt, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_re = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      check("reset rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset rsp_allowed", 32'(rsp_allowed), 32'h0);
      check("reset cfg_rdata", cfg_rdata, 32'h0);
      rst_n = 1'b1;
   endtask

   logic [31:0] pool [4];

   initial begin
      pool[0] = 32'h8000_0000; pool[1] = 32'h2000_0000;
      pool[2] = 32'h0000_0000; pool[3] = 32'h4000_0000;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      req_valid = 1'b0; req_addr = '0; req_type = '0; rsp_ready = 1'b1;
      model_reset();
      @(negedge clk);
      do_reset();
      rd(6'h02);
      rd(6'h01);
      look(32'h8000_1000, 2'd2);
      idle();
      // Region 1: r/w memory, no execute
      wr(6'h04, 32'h2000_0000);
      wr(6'h05, 32'h0000_0FFF);
      wr(6'h06, 32'h0000_002B);
      look(32'h2000_0004, 2'd1);
      look(32'h2000_0004, 2'd2);
      rd(6'h20);
      rd(6'h21);
      look(32'h5000_0000, 2'd0);
      rd(6'h21);
      wr(6'h21, 32'h1);
      rd(6'h21);
      look(32'h5000_0000, 2'd0);
      rd(6'h20);
      rd(6'h21);
      look(32'h8000_0000, 2'd3);
      rd(6'h20);
      // Clear in the same cycle as a new fault
      step(1'b1, 1'b0, 6'h21, 32'h1, 1'b1, 32'h2000_0010, 2'd2, 1'b1);
      rd(6'h21);
      rd(6'h20);
      rd(6'h07);
      rd(6'h3F);
      // Lock region 1
      wr(6'h06, 32'h0000_00AB);
      wr(6'h04, 32'h0);
      wr(6'h06, 32'h0000_002F);
      rd(6'h04);
      rd(6'h06);
      // Backpressure
      look(32'h8000_0100, 2'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, 32'h2000_0100, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++) look(32'h2000_0000 + 32'(i * 4), 2'(i));
      idle();
      // Fault counter
      wr(6'h22, 32'h0);
      for (int i = 0; i < 5; i++) look(32'h5000_0000 + 32'(i), 2'd0);
      rd(6'h22);
      wr(6'h22, 32'h0);
      rd(6'h22);
      step(1'b1, 1'b0, 6'h22, 32'h0, 1'b1, 32'h6000_0000, 2'd1, 1'b1);
      rd(6'h22);
      // Reset with a stalled response pending
      step(1'b0, 1'b0, 6'h0, 32'h0, 1'b1, 32'h8000_0000, 2'd0, 1'b0);
      do_reset();
      rd(6'h04);
      rd(6'h06);
      rd(6'h21);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic we, re, rv, rr;
         logic [5:0] a;
         logic [31:0] wd, ra;
         logic [1:0] rt;
         if (i == 300) do_reset();
         we = ($urandom_range(0, 3) == 0);
         re = ($urandom_range(0, 2) == 0);
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 3) != 0);
         rt = 2'($urandom_range(0, 3));
         a  = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = {4'b1000, 2'($urandom_range(0, 3))};
         case (a[1:0])
            2'd0:    wd = pool[$urandom_range(0, 3)];
            2'd1:    wd = ($urandom_range(0, 1) == 1) ? 32'h0000_0FFF : 32'h0FFF_FFFF;
            default: wd = $urandom;
         endcase
         if (!a[5] && a[1:0] == 2'd2 && $urandom_range(0, 15) != 0) wd[7] = 1'b0;
         if (!a[5] && a[1:0] == 2'd2 && $urandom_range(0, 1) == 1) wd[5] = 1'b1;
         ra = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 8191));
         if ($urandom_range(0, 5) == 0) ra = $urandom;
         step(we, re, a, wd, rv, ra, rt, rr);
      end
      for (int i = 0; i < 32; i++) rd(6'(i));
      rd(6'h20);
      rd(6'h21);
      rd(6'h22);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
